pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_edge_sync.sv | 32 +++
 rtl/pwm_capture.sv | 125 ++++++++++++
 tb/tb_pwm_capture.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator/capture pair: state encodings,
// default counter width and the nominal PWM period.
package pwm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int PWM_PERIOD = 256;

  typedef logic [1:0] state_t;

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] HIGH      = 2'd1;
  localparam logic [1:0] LOW       = 2'd2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM line plus a history flop
// for edge detection. Both edges see the same latency, so counts stay exact.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM line, one strobed result per period,
// and flags a line stuck at 0% or 100% duty via an inactivity timeout.
import pwm_pkg::*;

// state     | meaning
// WAIT_RISE | discard partial period after reset/stuck, wait for first rise
// HIGH      | line high, counting high time and period
// LOW       | line low, counting rest of period
module pwm_capture #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] hi_inc;
  logic [CNT_W-1:0] per_inc;
  logic             level;
  logic             rise;
  logic             fall;
  logic             edge_seen;
  logic             timeout_hit;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // A low phase can approach TIMEOUT after a high phase did, so the period
  // counter saturates rather than trusting the timeout alone.
  assign hi_inc  = (hi_cnt  == CNT_MAX) ? hi_cnt  : hi_cnt  + CNT_ONE;
  assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;

  assign edge_seen   = rise | fall;
  assign timeout_hit = !edge_seen && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_RISE;
      hi_cnt      <= '0;
      per_cnt     <= '0;
      hi_lat      <= '0;
      idle_cnt    <= '0;
      duty_cnt    <= '0;
      period_cnt  <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (edge_seen) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + CNT_ONE;
      end

      if (rise) begin
        stuck <= 1'b0;
      end

      // An edge in the same cycle suppresses the timeout via timeout_hit.
      if (timeout_hit) begin
        stuck       <= 1'b1;
        stuck_level <= level;
        state       <= WAIT_RISE;
      end else begin
        case (state)
          WAIT_RISE: begin
            if (rise) begin
              hi_cnt  <= CNT_ONE;
              per_cnt <= CNT_ONE;
              state   <= HIGH;
            end
          end
          HIGH: begin
            hi_cnt  <= hi_inc;
            per_cnt <= per_inc;
            if (fall) begin
              hi_lat <= hi_cnt;
              state  <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              duty_cnt   <= hi_lat;
              period_cnt <= per_cnt;
              meas_valid <= 1'b1;
              hi_cnt     <= CNT_ONE;
              per_cnt    <= CNT_ONE;
              state      <= HIGH;
            end else begin
              per_cnt <= per_inc;
            end
          end
          default: begin
            state <= WAIT_RISE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives hand-built PWM waveforms and checks
// strobed measurements, timing and stuck detection against hand-derived values.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 4096;
  localparam int SYNC_LAT = 3;  // pin change -> FSM action: s1, s2, then edge registered

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] duty_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .duty_cnt    (duty_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int duty;
    int period;
  } strobe_t;

  strobe_t q[$];
  always @(negedge clk) begin
    if (meas_valid === 1'b1) q.push_back(strobe_t'{cyc, int'(duty_cnt), int'(period_cnt)});
  end

  int checks = 0;
  int errors = 0;
  int last_rise = 0;
  int last_fall = 0;

  task automatic drive_level(input logic v, input int n);
    @(posedge clk);
    #1;
    if (v && !pwm_in) last_rise = cyc;
    if (!v && pwm_in) last_fall = cyc;
    pwm_in = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drive_period(input int h, input int p);
    drive_level(1'b1, h);
    drive_level(1'b0, p - h);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (duty_cnt !== '0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty_cnt); end
    checks++; if (period_cnt !== '0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_cnt); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", meas_valid); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
    checks++; if (stuck_level !== 1'b0) begin errors++; $display("FAIL reset_stuck_level: got %b expected 0", stuck_level); end
  endtask

  task automatic test_basic();
    int r0;
    do_reset();
    drive_period(64, PWM_PERIOD);
    r0 = last_rise;
    repeat (4) drive_period(64, PWM_PERIOD);
    repeat (8) @(negedge clk);
    checks++; if (q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", q.size()); end
    if (q.size() > 0) begin
      checks++;
      if (q[0].t !== r0 + PWM_PERIOD + SYNC_LAT) begin
        errors++; $display("FAIL basic_first_time: got %0d expected %0d", q[0].t, r0 + PWM_PERIOD + SYNC_LAT);
      end
    end
    for (int i = 0; i < q.size() && i < 4; i++) begin
      checks++; if (q[i].duty !== 64) begin errors++; $display("FAIL basic_duty[%0d]: got %0d expected 64", i, q[i].duty); end
      checks++; if (q[i].period !== 256) begin errors++; $display("FAIL basic_period[%0d]: got %0d expected 256", i, q[i].period); end
      if (i > 0) begin
        checks++;
        if (q[i].t - q[i-1].t !== 256) begin
          errors++; $display("FAIL basic_spacing[%0d]: got %0d expected 256", i, q[i].t - q[i-1].t);
        end
      end
    end
  endtask

  task automatic test_duty_step();
    int drv[5] = '{64, 64, 200, 200, 200};
    int exp_d[4] = '{64, 64, 200, 200};
    do_reset();
    for (int i = 0; i < 5; i++) drive_period(drv[i], PWM_PERIOD);
    repeat (8) @(negedge clk);
    checks++; if (q.size() !== 4) begin errors++; $display("FAIL step_count: got %0d expected 4", q.size()); end
    for (int i = 0; i < q.size() && i < 4; i++) begin
      checks++; if (q[i].duty !== exp_d[i]) begin errors++; $display("FAIL step_duty[%0d]: got %0d expected %0d", i, q[i].duty, exp_d[i]); end
      checks++; if (q[i].period !== 256) begin errors++; $display("FAIL step_period[%0d]: got %0d expected 256", i, q[i].period); end
    end
  endtask

  task automatic test_extremes();
    int drv[5] = '{1, 1, 255, 255, 1};
    int exp_d[4] = '{1, 1, 255, 255};
    do_reset();
    for (int i = 0; i < 5; i++) drive_period(drv[i], PWM_PERIOD);
    repeat (8) @(negedge clk);
    checks++; if (q.size() !== 4) begin errors++; $display("FAIL ext_count: got %0d expected 4", q.size()); end
    for (int i = 0; i < q.size() && i < 4; i++) begin
      checks++; if (q[i].duty !== exp_d[i]) begin errors++; $display("FAIL ext_duty[%0d]: got %0d expected %0d", i, q[i].duty, exp_d[i]); end
      checks++; if (q[i].period !== 256) begin errors++; $display("FAIL ext_period[%0d]: got %0d expected 256", i, q[i].period); end
    end
  endtask

  task automatic test_stuck_high();
    int t0;
    int r;
    do_reset();
    repeat (3) drive_period(64, PWM_PERIOD);
    drive_level(1'b1, 1);
    t0 = last_rise;
    while (stuck !== 1'b1 && cyc < t0 + 2 * TIMEOUT) @(negedge clk);
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL sh_stuck: got %b expected 1", stuck); end
    checks++;
    if (cyc - t0 !== TIMEOUT + SYNC_LAT) begin
      errors++; $display("FAIL sh_latency: got %0d expected %0d", cyc - t0, TIMEOUT + SYNC_LAT);
    end
    checks++; if (stuck_level !== 1'b1) begin errors++; $display("FAIL sh_level: got %b expected 1", stuck_level); end
    checks++; if (q.size() !== 3) begin errors++; $display("FAIL sh_count: got %0d expected 3", q.size()); end
    checks++; if (duty_cnt !== 16'd64) begin errors++; $display("FAIL sh_duty_hold: got %0d expected 64", duty_cnt); end
    checks++; if (period_cnt !== 16'd256) begin errors++; $display("FAIL sh_period_hold: got %0d expected 256", period_cnt); end

    // A falling edge alone must not release stuck; the next rise does.
    drive_level(1'b0, 100);
    @(negedge clk);
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL rec_stuck_after_fall: got %b expected 1", stuck); end
    drive_level(1'b1, 64);
    r = last_rise;
    @(negedge clk);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL rec_stuck_cleared: got %b expected 0", stuck); end
    drive_level(1'b0, 192);
    drive_period(64, PWM_PERIOD);
    repeat (8) @(negedge clk);
    checks++; if (q.size() !== 4) begin errors++; $display("FAIL rec_count: got %0d expected 4", q.size()); end
    if (q.size() >= 4) begin
      checks++;
      if (q[3].t !== r + PWM_PERIOD + SYNC_LAT) begin
        errors++; $display("FAIL rec_time: got %0d expected %0d", q[3].t, r + PWM_PERIOD + SYNC_LAT);
      end
      checks++; if (q[3].duty !== 64) begin errors++; $display("FAIL rec_duty: got %0d expected 64", q[3].duty); end
      checks++; if (q[3].period !== 256) begin errors++; $display("FAIL rec_period: got %0d expected 256", q[3].period); end
    end
  endtask

  task automatic test_stuck_low();
    int f;
    f = last_fall;
    while (stuck !== 1'b1 && cyc < f + 2 * TIMEOUT) @(negedge clk);
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL sl_stuck: got %b expected 1", stuck); end
    checks++;
    if (cyc - f !== TIMEOUT + SYNC_LAT) begin
      errors++; $display("FAIL sl_latency: got %0d expected %0d", cyc - f, TIMEOUT + SYNC_LAT);
    end
    checks++; if (stuck_level !== 1'b0) begin errors++; $display("FAIL sl_level: got %b expected 0", stuck_level); end
    checks++; if (duty_cnt !== 16'd64) begin errors++; $display("FAIL sl_duty_hold: got %0d expected 64", duty_cnt); end
    checks++; if (period_cnt !== 16'd256) begin errors++; $display("FAIL sl_period_hold: got %0d expected 256", period_cnt); end
    checks++; if (q.size() !== 4) begin errors++; $display("FAIL sl_count: got %0d expected 4", q.size()); end
  endtask

  task automatic test_reset_mid();
    int r2;
    do_reset();
    repeat (2) drive_period(64, PWM_PERIOD);
    drive_level(1'b1, 64);
    // Pin falls now, but the FSM is still in HIGH for the sync latency when rst lands.
    @(posedge clk);
    #1;
    pwm_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (duty_cnt !== '0) begin errors++; $display("FAIL rm_duty: got %0d expected 0", duty_cnt); end
    checks++; if (period_cnt !== '0) begin errors++; $display("FAIL rm_period: got %0d expected 0", period_cnt); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", meas_valid); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL rm_stuck: got %b expected 0", stuck); end
    q.delete();
    repeat (150) @(posedge clk);
    drive_period(64, PWM_PERIOD);
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rm_early_strobe: got %0d expected 0", q.size()); end
    drive_period(64, PWM_PERIOD);
    r2 = last_rise;
    repeat (8) @(negedge clk);
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL rm_count: got %0d expected 1", q.size()); end
    if (q.size() >= 1) begin
      checks++;
      if (q[0].t !== r2 + SYNC_LAT) begin
        errors++; $display("FAIL rm_time: got %0d expected %0d", q[0].t, r2 + SYNC_LAT);
      end
      checks++; if (q[0].duty !== 64) begin errors++; $display("FAIL rm_duty_meas: got %0d expected 64", q[0].duty); end
      checks++; if (q[0].period !== 256) begin errors++; $display("FAIL rm_period_meas: got %0d expected 256", q[0].period); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_step();
    test_extremes();
    test_stuck_high();
    test_stuck_low();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
